// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 byte writer.
// The init command table and the long-wait classifier live here.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } lcd_state_t;

  localparam int LCD_CNT_W = 20;
  localparam int LCD_INIT_LEN = 4;

  localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;

  function automatic logic [7:0] lcd_init_rom(
    input logic [1:0] idx
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = LCD_CMD_FUNC_SET;
      2'd1:    b = LCD_CMD_DISP_ON;
      2'd2:    b = LCD_CMD_CLEAR;
      default: b = LCD_CMD_ENTRY;
    endcase
    return b;
  endfunction

  // clear (0x01) and home (0x02/0x03) need the long settle time
  function automatic logic lcd_long_wait(
    input logic       rs,
    input logic [7:0] data
  );
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_byte_writer_delay.sv
// Loadable down-counter shared by every timed state of the writer.
// Loading N yields exactly N cycles until done.
module lcd_delay_counter
  import lcd_pkg::*;
#(
  parameter logic [LCD_CNT_W-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LCD_CNT_W-1:0] len,
  output logic [LCD_CNT_W-1:0] value,
  output logic                 done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= len - 1'b1;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign done = (value == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// HD44780 write engine: power-up init, then one timed bus write per byte.
// Define LCD_WR_COUNT_EN to add the saturating wr_count output.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned EN_HIGH_CYC    = 25,
  parameter int unsigned HOLD_CYC       = 2,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       LCD_ON,
  output logic       LCD_BLON
`ifdef LCD_WR_COUNT_EN
  ,
  output logic [15:0] wr_count
`endif
);

  localparam logic [LCD_CNT_W-1:0] PWR_LEN = LCD_CNT_W'(POWERUP_CYC);
  localparam logic [LCD_CNT_W-1:0] SET_LEN = LCD_CNT_W'(SETUP_CYC);
  localparam logic [LCD_CNT_W-1:0] ENH_LEN = LCD_CNT_W'(EN_HIGH_CYC);
  localparam logic [LCD_CNT_W-1:0] HLD_LEN = LCD_CNT_W'(HOLD_CYC);
  localparam logic [LCD_CNT_W-1:0] CMD_LEN = LCD_CNT_W'(CMD_WAIT_CYC);
  localparam logic [LCD_CNT_W-1:0] CLR_LEN = LCD_CNT_W'(CLEAR_WAIT_CYC);

  lcd_state_t state, state_nx;

  logic                 cnt_load;
  logic [LCD_CNT_W-1:0] cnt_len;
  logic [LCD_CNT_W-1:0] cnt_val;
  logic                 cnt_done;
  logic [1:0]           idx;
  logic                 take;
  logic                 rom_load;
  logic                 init_step;
  logic                 init_fin;

  assign take     = in_valid && in_ready;
  assign LCD_RW   = 1'b0;
  assign LCD_BLON = 1'b0;

  lcd_delay_counter #(
    .RST_VAL(PWR_LEN - 1'b1)
  ) u_delay (
    .clk  (CLOCK_50),
    .rst  (reset),
    .load (cnt_load),
    .len  (cnt_len),
    .value(cnt_val),
    .done (cnt_done)
  );

  always_comb begin
    state_nx  = state;
    cnt_load  = 1'b0;
    cnt_len   = SET_LEN;
    rom_load  = 1'b0;
    init_step = 1'b0;
    init_fin  = 1'b0;
    case (state)
      S_POWERUP: begin
        // counter comes out of reset preloaded with the power-up delay
        if (cnt_val == '0) state_nx = S_INIT;
      end
      S_INIT: begin
        state_nx = S_SETUP;
        cnt_load = 1'b1;
        cnt_len  = SET_LEN;
        rom_load = 1'b1;
      end
      S_SETUP: begin
        if (cnt_done) begin
          state_nx = S_EN_HI;
          cnt_load = 1'b1;
          cnt_len  = ENH_LEN;
        end
      end
      S_EN_HI: begin
        if (cnt_done) begin
          state_nx = S_HOLD;
          cnt_load = 1'b1;
          cnt_len  = HLD_LEN;
        end
      end
      S_HOLD: begin
        if (cnt_done) begin
          state_nx = S_WAIT;
          cnt_load = 1'b1;
          cnt_len  = lcd_long_wait(LCD_RS, LCD_DATA)
                   ? CLR_LEN : CMD_LEN;
        end
      end
      S_WAIT: begin
        if (cnt_done) begin
          if (init_done) begin
            state_nx = S_IDLE;
          end else if (idx == 2'(LCD_INIT_LEN - 1)) begin
            state_nx = S_IDLE;
            init_fin = 1'b1;
          end else begin
            state_nx  = S_INIT;
            init_step = 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (take) begin
          state_nx = S_SETUP;
          cnt_load = 1'b1;
          cnt_len  = SET_LEN;
        end
      end
      default: state_nx = S_POWERUP;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= S_POWERUP;
      idx       <= '0;
      init_done <= 1'b0;
      in_ready  <= 1'b0;
      LCD_EN    <= 1'b0;
      LCD_ON    <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DATA  <= '0;
    end else begin
      state    <= state_nx;
      LCD_ON   <= 1'b1;
      LCD_EN   <= (state_nx == S_EN_HI);
      in_ready <= (state == S_IDLE) && !take;
      if (rom_load) begin
        LCD_RS   <= 1'b0;
        LCD_DATA <= lcd_init_rom(idx);
      end else if (take) begin
        LCD_RS   <= in_rs;
        LCD_DATA <= in_data;
      end
      if (init_step) idx <= idx + 2'd1;
      if (init_fin) init_done <= 1'b1;
    end
  end

`ifdef LCD_WR_COUNT_EN
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
    end else if (state == S_EN_HI && state_nx != S_EN_HI
                 && wr_count != 16'hFFFF) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: per-cycle compare against a schedule model.
// Build with LCD_WR_COUNT_EN defined to also cover wr_count.
module tb_lcd_byte_writer;

  localparam int P    = 100;
  localparam int SET  = 2;
  localparam int ENH  = 25;
  localparam int HLD  = 2;
  localparam int CMDW = 20;
  localparam int CLRW = 50;
  localparam int WCYC = SET + ENH + HLD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, init_done;
  logic [7:0] LCD_DATA;
  logic       LCD_EN, LCD_RW, LCD_RS, LCD_ON, LCD_BLON;
`ifdef LCD_WR_COUNT_EN
  logic [15:0] wr_count;
`endif

  lcd_byte_writer #(
    .POWERUP_CYC   (P),
    .CMD_WAIT_CYC  (CMDW),
    .CLEAR_WAIT_CYC(CLRW)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rs    (in_rs),
    .in_data  (in_data),
    .init_done(init_done),
    .LCD_DATA (LCD_DATA),
    .LCD_EN   (LCD_EN),
    .LCD_RW   (LCD_RW),
    .LCD_RS   (LCD_RS),
    .LCD_ON   (LCD_ON),
    .LCD_BLON (LCD_BLON)
`ifdef LCD_WR_COUNT_EN
    ,
    .wr_count (wr_count)
`endif
  );

  initial begin
    #5;
    forever begin
      clk = 1'b1;
      #10;
      clk = 1'b0;
      #10;
    end
  end

  logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  int checks = 0;
  int failures = 0;
  int cyc;

  // model: each write is a job that starts setup at cycle q_s
  int         q_s [$];
  logic       q_rs [$];
  logic [7:0] q_d [$];
  int         cur;
  int         ready_at;
  int         done_at;
  int         acc_c;

  // producer
  logic       p_rs [$];
  logic [7:0] p_d [$];
  int         gap;
  bit         b2b;
  bit         pend;

  // observed DUT events
  int         rise_c [$];
  int         fall_c [$];
  logic [7:0] fall_d [$];
  logic       fall_rs [$];
  logic       prev_en, prev_ready, prev_done;
  int         ready_rise_c, done_rise_c;

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && d[7:2] == 6'd0 && d != 8'd0) ? CLRW : CMDW;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    int s, w;
    cyc = 0;
    q_s.delete(); q_rs.delete(); q_d.delete();
    p_rs.delete(); p_d.delete();
    rise_c.delete(); fall_c.delete();
    fall_d.delete(); fall_rs.delete();
    cur = -1; acc_c = -1; gap = 0; pend = 0;
    in_valid = 1'b0;
    prev_en = 0; prev_ready = 0; prev_done = 0;
    ready_rise_c = -1; done_rise_c = -1;
    s = P + 1;
    w = 0;
    for (int i = 0; i < 4; i++) begin
      q_s.push_back(s); q_rs.push_back(1'b0); q_d.push_back(rom[i]);
      w = wait_of(1'b0, rom[i]);
      if (i < 3) s = s + WCYC + 1 + w;
    end
    done_at  = s + WCYC + w;
    ready_at = s + WCYC + w + 1;
  endtask

  task automatic step();
    logic       e_en, e_rs;
    logic [7:0] e_d;
    int         e_wr;
    while (cur + 1 < q_s.size() && q_s[cur+1] <= cyc) cur++;
    e_en = cur >= 0 && cyc >= q_s[cur] + SET
           && cyc < q_s[cur] + SET + ENH;
    e_rs = cur >= 0 ? q_rs[cur] : 1'b0;
    e_d  = cur >= 0 ? q_d[cur] : 8'h00;
    e_wr = 0;
    for (int i = 0; i < q_s.size(); i++)
      if (cyc >= q_s[i] + SET + ENH) e_wr++;
    chk("lcd_en", LCD_EN, e_en);
    chk("lcd_rs", LCD_RS, e_rs);
    chk("lcd_data", LCD_DATA, e_d);
    chk("in_ready", in_ready, cyc >= ready_at);
    chk("init_done", init_done, cyc >= done_at);
    chk("lcd_on", LCD_ON, cyc >= 1);
    chk("lcd_rw", LCD_RW, 0);
    chk("lcd_blon", LCD_BLON, 0);
`ifdef LCD_WR_COUNT_EN
    chk("wr_count", wr_count, e_wr);
`endif
    if (LCD_EN && !prev_en) rise_c.push_back(cyc);
    if (!LCD_EN && prev_en) begin
      fall_c.push_back(cyc);
      fall_d.push_back(LCD_DATA);
      fall_rs.push_back(LCD_RS);
    end
    if (in_ready && !prev_ready) ready_rise_c = cyc;
    if (init_done && !prev_done) done_rise_c = cyc;
    prev_en = LCD_EN; prev_ready = in_ready; prev_done = init_done;

    if (pend) begin
      pend = 0;
      in_valid = 1'b0;
      void'(p_rs.pop_front());
      void'(p_d.pop_front());
      gap = b2b ? 0 : int'($urandom_range(0, 6));
    end
    if (!in_valid && p_d.size() > 0) begin
      if (gap > 0) gap--;
      else begin
        in_valid = 1'b1;
        in_rs = p_rs[0];
        in_data = p_d[0];
      end
    end
    if (in_valid && cyc >= ready_at) begin
      q_s.push_back(cyc + 1); q_rs.push_back(in_rs);
      q_d.push_back(in_data);
      acc_c = cyc + 1;
      ready_at = cyc + 1 + WCYC + wait_of(in_rs, in_data) + 1;
      pend = 1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((p_d.size() > 0 || pend || cyc < ready_at) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("timeout_idle", 1, 0);
    step();
  endtask

  task automatic send_one(input logic rs, input logic [7:0] d,
                          input string name, input int exp_gap);
    p_rs.push_back(rs); p_d.push_back(d);
    run_until_idle(500);
    chk({name, "_ready_gap"}, ready_rise_c - acc_c, exp_gap);
    chk({name, "_en_rise"}, rise_c[rise_c.size()-1] - acc_c, 2);
    chk({name, "_en_width"},
        fall_c[fall_c.size()-1] - rise_c[rise_c.size()-1], 25);
    chk({name, "_data"}, fall_d[fall_d.size()-1], d);
    chk({name, "_rs"}, fall_rs[fall_rs.size()-1], rs);
  endtask

  task automatic check_init(input string name);
    chk({name, "_first_rise"}, rise_c.size() > 0 ? rise_c[0] : -1, 103);
    chk({name, "_done_rise"}, done_rise_c, 330);
    chk({name, "_falls"}, fall_d.size(), 4);
    if (fall_d.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s_byte%0d", name, i), fall_d[i], rom[i]);
        chk($sformatf("%s_rs%0d", name, i), fall_rs[i], 0);
      end
      chk({name, "_width"}, fall_c[0] - rise_c[0], 25);
    end
`ifdef LCD_WR_COUNT_EN
    chk({name, "_wr_count"}, wr_count, 4);
`endif
  endtask

  initial begin
    int n0, n;
    b2b = 0;
    model_reset();
    #30;
    rst = 1'b0;
    @(negedge clk);

    run_until_idle(1000);
    check_init("init");

    send_one(1'b1, 8'h31, "d31", 50);
    send_one(1'b0, 8'h01, "clr", 80);
    send_one(1'b0, 8'h80, "ddram", 50);

    b2b = 1;
    n0 = fall_d.size();
    for (int i = 0; i < 16; i++) begin
      p_rs.push_back(1'b1);
      p_d.push_back(8'h30 + 8'(i));
    end
    run_until_idle(3000);
    chk("b2b_count", fall_d.size() - n0, 16);
    if (fall_d.size() - n0 >= 16)
      for (int i = 0; i < 16; i++)
        chk($sformatf("b2b_byte%0d", i), fall_d[n0+i], 8'h30 + 8'(i));
`ifdef LCD_WR_COUNT_EN
    chk("wr_count_after_b2b", wr_count, 23);
`endif

    b2b = 0;
    for (int i = 0; i < 25; i++) begin
      logic [7:0] d;
      logic       r;
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r = 1'b0;
        d = 8'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 0) d = 8'h80;
      end
      p_rs.push_back(r); p_d.push_back(d);
    end
    run_until_idle(10000);

    acc_c = -1;
    p_rs.push_back(1'b1); p_d.push_back(8'h41);
    n = 0;
    while (!(acc_c > 0 && cyc == acc_c + SET + 5) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) chk("timeout_en_hi", 1, 0);
    chk("pre_reset_en", LCD_EN, 1);
    rst = 1'b1;
    #1;
    chk("reset_en", LCD_EN, 0);
    chk("reset_on", LCD_ON, 0);
    chk("reset_ready", in_ready, 0);
    chk("reset_data", LCD_DATA, 0);
    chk("reset_done", init_done, 0);
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    run_until_idle(1000);
    check_init("reinit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
